// File: rtl/vsu_pkg.sv
// Shared constants and FSM state type for the vector store unit.
// Default geometry: 16 lanes of 16-bit elements, 16-bit word addresses.
package vsu_pkg;

    localparam int LANES  = 16;
    localparam int ELEM_W = 16;
    localparam int ADDR_W = 16;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } vsu_state_e;

endpackage

// File: rtl/vsu_addr_gen.sv
// Running store address: loads base on start, steps by stride (VSU_STRIDE_EN) or by 1 per transfer.
// Latency: address registered, valid the cycle after load/step.
// Backpressure: only advances on step_i, so the address holds while the memory stalls.
module vsu_addr_gen
    import vsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] inc;

`ifdef VSU_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_q <= '0;
        end else if (load_i) begin
            stride_q <= stride_i;
        end
    end

    assign inc = stride_q;
`else
    logic unused_stride;

    assign unused_stride = ^stride_i;
    assign inc           = ADDR_W'(1);
`endif

    // Wraps modulo 2^ADDR_W by construction.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = base_i;
        end else if (step_i) begin
            addr_d = addr_q + inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/vector_store_unit.sv
// VST engine: writes a 16-lane vector to memory one element per req/ack beat (VSU_STRIDE_EN enables strided addressing).
// Latency: first request the cycle after start, 16 beats minimum, done pulse one cycle after the last ack.
// Backpressure: mem_ack low holds address/data and adds one cycle per stalled beat; start ignored while busy.
module vector_store_unit
    import vsu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LANES*ELEM_W-1:0] vdata,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [ELEM_W-1:0]       mem_wdata,
    input  logic                    mem_ack
);

    vsu_state_e              state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [LANE_W-1:0]       lane_nx;
    logic [LANES*ELEM_W-1:0] vdata_q, vdata_d;
    logic [ELEM_W-1:0]       wdata_q, wdata_d;
    logic                    accept;
    logic                    xfer;
    logic                    last;

    assign accept  = (state_q == IDLE) && start;
    assign xfer    = (state_q == SEND) && mem_ack;
    assign last    = (lane_q == LANE_W'(LANES - 1));
    assign lane_nx = lane_q + LANE_W'(1);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        vdata_d = vdata_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    lane_d  = '0;
                    vdata_d = vdata;
                    wdata_d = vdata[ELEM_W-1:0];
                end
            end
            SEND: begin
                // Next element is preloaded into the output register so mem_wdata stays a flop.
                if (mem_ack) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        lane_d  = lane_nx;
                        wdata_d = vdata_q[32'(lane_nx)*ELEM_W +: ELEM_W];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            vdata_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            vdata_q <= vdata_d;
            wdata_q <= wdata_d;
        end
    end

    vsu_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .base_i   (base_addr),
        .stride_i (stride),
        .step_i   (xfer),
        .addr_o   (mem_addr)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_req   = (state_q == SEND);
    assign mem_we    = mem_req;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed bench for vector_store_unit: checks reset values, per-beat address/data, stall hold,
// done timing, address wrap, stride, ignored start and mid-store reset.
module tb_vector_store_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] vdata = '0;
    logic [15:0]  base_addr = '0;
    logic [15:0]  stride = '0;
    logic         busy;
    logic         done;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_ack = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    vector_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vdata     (vdata),
        .base_addr (base_addr),
        .stride    (stride),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_req"},  32'(mem_req), 32'd0);
    endtask

    // Called at a negedge. Runs one store and checks every beat.
    // alt_ack: ack low on odd cycles after acceptance. inject_at: cycle to pulse a stray start (0 = none).
    // abort_lane: assert reset while this lane is presented (-1 = none).
    task automatic do_store(input logic [15:0] base, input logic [15:0] strd, input bit alt_ack,
                            input int exp_done, input int inject_at, input int abort_lane);
        logic [15:0] eff;
        logic [15:0] exp_addr;
        int          lane;
        bit          seen_done;
`ifdef VSU_STRIDE_EN
        eff = strd;
`else
        eff = 16'd1;
`endif
        for (int i = 0; i < 16; i++) begin
            vdata[i*16 +: 16] = 16'h3C00 + 16'(i);
        end
        base_addr = base;
        stride    = strd;
        mem_ack   = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        lane      = 0;
        seen_done = 1'b0;
        for (int c = 1; c <= 60 && !seen_done; c++) begin
            mem_ack = alt_ack ? (c % 2 == 0) : 1'b1;
            if (c == inject_at) begin
                start     = 1'b1;
                base_addr = 16'h0BAD;
                vdata     = {16{16'hDEAD}};
            end else begin
                start     = 1'b0;
            end
            if (abort_lane >= 0 && mem_req && lane == abort_lane) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_req", 32'(mem_req), 32'd0);
                chk("abort_we", 32'(mem_we), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                return;
            end
            if (mem_req) begin
                exp_addr = base + 16'(lane) * eff;
                chk($sformatf("addr_l%0d", lane), 32'(mem_addr), 32'(exp_addr));
                chk($sformatf("data_l%0d", lane), 32'(mem_wdata), 32'(16'h3C00 + 16'(lane)));
                chk("we_eq_req", 32'(mem_we), 32'd1);
                chk("busy_send", 32'(busy), 32'd1);
                if (mem_ack) begin
                    lane++;
                end
            end else if (done) begin
                chk("done_cycle", 32'(c), 32'(exp_done));
                chk("lane_count", 32'(lane), 32'd16);
                chk("busy_done", 32'(busy), 32'd1);
                seen_done = 1'b1;
            end else begin
                chk("unexpected_idle", 32'(c), 32'(exp_done));
                seen_done = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(done === 1'b0 && seen_done), 32'd1);
        chk_idle("post_done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_idle("reset");
        chk("reset_we", 32'(mem_we), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        // Basic store, ack tied high.
        do_store(16'h0100, 16'h0000, 1'b0, 17, 0, -1);
        // Same store with ack low every other cycle.
        do_store(16'h0100, 16'h0000, 1'b1, 33, 0, -1);
        // Address wrap through 0xFFFF.
        do_store(16'hFFF8, 16'h0000, 1'b0, 17, 0, -1);
        // Strided (or unit-stride without the macro).
        do_store(16'h0200, 16'h0010, 1'b0, 17, 0, -1);
        // Zero stride.
        do_store(16'h0400, 16'h0000, 1'b0, 17, 0, -1);
        // Stray start during SEND.
        do_store(16'h0100, 16'h0000, 1'b0, 17, 4, -1);
        @(negedge clk);
        chk_idle("stray_start_no_restart");

        // Reset at lane 5, then a fresh store.
        do_store(16'h0500, 16'h0000, 1'b0, 17, 0, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle("in_reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");
        do_store(16'h0300, 16'h0000, 1'b0, 17, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vector_store_unit.md
# vector_store_unit

Serialises one 256-bit vector register (16 lanes × 16-bit half-precision elements) into data memory for the VST instruction. It sits beside the ALU in the execute stage: the ALU and register file hand it a vector and base address, and it writes the elements one at a time over the 16-bit data-memory write port with a req/ack handshake. It is the memory-writer counterpart of the vector-load path.

## Interface
- LANES, 16, number of elements per vector
- ELEM_W, 16, element width in bits
- ADDR_W, 16, data-memory word-address width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a store; sampled only in IDLE
- vdata  in  LANES*ELEM_W  vector to store; lane i = vdata[16i+15:16i]
- base_addr  in  ADDR_W  word address of lane 0
- stride  in  ADDR_W  word stride between lanes (used only with VSU_STRIDE_EN)
- busy  out  1  high from the cycle after start acceptance through the DONE cycle
- done  out  1  one-cycle pulse after the last element is acknowledged
- mem_req  out  1  write request valid
- mem_we  out  1  write enable, equals mem_req
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  ELEM_W  write data
- mem_ack  in  1  memory accepts the current write this cycle

## Operation
- States: IDLE, SEND, DONE.
- IDLE: start=1 captures vdata, base_addr and stride into internal registers, clears lane counter to 0, goes to SEND. Inputs are not sampled again until the next IDLE.
- SEND: mem_req=1, mem_addr = base + lane*stride (mod 2^ADDR_W), mem_wdata = captured lane[lane]. A transfer completes on a cycle where mem_req && mem_ack. On completion: lane 15 -> DONE; otherwise lane increments and next element is presented the following cycle with mem_req kept high.
- mem_addr/mem_wdata stable while mem_req high and mem_ack low.
- DONE: done=1, mem_req=0, busy=1 for one cycle, then IDLE.
- start in SEND or DONE: ignored, not queued.
- Address arithmetic is ADDR_W-bit unsigned, wraps silently (0xFFFF+1 = 0x0000). No error output.
- Reset values: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state IDLE, lane=0.
- rst_n asserted mid-store: immediate return to IDLE, mem_req drops asynchronously, no done pulse; partially written elements remain in memory.

## Timing
- Start accepted at edge N; mem_req high from N+1.
- mem_ack held high: one element per cycle, transfers at N+1..N+16, done at N+17, start next accepted at N+18.
- Each ack-low cycle adds exactly one cycle of latency.
- mem_ack ignored when mem_req=0.
- All outputs registered; no combinational path from mem_ack to mem_addr/mem_wdata within a cycle.

## Configuration
- VSU_STRIDE_EN defined: stride captured at start; lane address = base + lane*stride; stride 0 writes all lanes to base (last write wins in memory).
- Undefined: stride port ignored, no stride register, address = base + lane.

## Structure
- Package vsu_pkg: state enum (IDLE, SEND, DONE), LANES, ELEM_W, ADDR_W defaults, lane-index width constant.
- One sub-module vsu_addr_gen: holds current address, loads base on start, adds stride (or 1) on each completed transfer; replaces the multiply.

## Test plan
- Reset, then idle: all outputs 0; start with vdata lanes = 0x3C00+i, base 0x0100, ack tied 1 -> writes 0x3C00..0x3C0F to 0x0100..0x010F on 16 consecutive cycles, done at start+17.
- Same store, mem_ack low every other cycle -> addr/data held stable during stalls, done at start+33, no duplicated or skipped lane.
- base 0xFFF8, ack 1 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
- VSU_STRIDE_EN, base 0x0200, stride 0x0010 -> addresses 0x0200, 0x0210 … 0x02F0; without macro same stimulus -> 0x0200..0x020F.
- start pulsed during SEND with different vdata/base -> ignored; original store completes unchanged, single done pulse.
- rst_n low at lane 5 -> mem_req 0 immediately, no done; after release, new start writes lane 0 at its base_addr.
